// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for a 4x4 signed multiplier feeding an accumulator.
// Optional build macro: MAC_SAT_EN (accumulator saturates instead of wrapping).
module mac_seq_ctrl #(
  parameter int N_TERMS = 16,
  parameter int ACC_W   = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [3:0]       x,
  input  logic signed [3:0]       w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    ovf,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends combinationally on valid.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);

  state_t                  state, state_nxt;
  logic [7:0]              cnt;
  logic signed [7:0]       prod;
  logic                    pvalid;
  logic signed [ACC_W-1:0] acc;
  logic                    accept;
  logic                    clear;
  logic [ACC_W:0]          sum;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] acc_nxt;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == LAST_IDX)) state_nxt = DRAIN;
      end
      // Stay until the last product has landed in the accumulator.
      DRAIN: if (!pvalid) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // One extra bit holds the exact sum; the top two bits disagree on overflow.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W-7){prod[7]}}, prod};
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    acc_nxt = sum[ACC_W-1:0];
`ifdef MAC_SAT_EN
    if (sum_ovf) begin
      acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      prod   <= 8'sd0;
      pvalid <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      pvalid <= accept;
      if (accept) begin
        // Sign-extended operands: the low 8 bits of the product are exact.
        prod <= {{4{x[3]}}, x} * {{4{w[3]}}, w};
        cnt  <= cnt + 8'd1;
      end
      if (clear) begin
        acc <= '0;
        cnt <= 8'd0;
        ovf <= 1'b0;
      end else if (pvalid) begin
        acc <= acc_nxt;
        if (sum_ovf) ovf <= 1'b1;
      end
    end
  end

  assign acc_out   = acc;
  assign dbg_state = state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: three instances (16/12, 4/12, 4/8) driven with random
// gaps and operands and checked against an arithmetic dot-product model.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_s     [3];
  logic       in_valid_s  [3];
  logic       out_ready_s [3];
  logic [3:0] x_s         [3];
  logic [3:0] w_s         [3];
  logic       in_ready_s  [3];
  logic       out_valid_s [3];
  logic       ovf_s       [3];
  logic       busy_s      [3];
  logic [1:0] dbg_s       [3];
  logic [11:0] acc0, acc1;
  logic [7:0]  acc2;

  int checks = 0;
  int failures = 0;

  mac_seq_ctrl #(.N_TERMS(16), .ACC_W(12)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .x(x_s[0]), .w(w_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .acc_out(acc0), .ovf(ovf_s[0]), .busy(busy_s[0]),
    .dbg_state(dbg_s[0]));

  mac_seq_ctrl #(.N_TERMS(4), .ACC_W(12)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .x(x_s[1]), .w(w_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .acc_out(acc1), .ovf(ovf_s[1]), .busy(busy_s[1]),
    .dbg_state(dbg_s[1]));

  mac_seq_ctrl #(.N_TERMS(4), .ACC_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .x(x_s[2]), .w(w_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .acc_out(acc2), .ovf(ovf_s[2]), .busy(busy_s[2]),
    .dbg_state(dbg_s[2]));

  function automatic int acc_of(input int idx);
    if (idx == 0) return int'($signed(acc0));
    else if (idx == 1) return int'($signed(acc1));
    return int'($signed(acc2));
  endfunction

  // Reference: running signed sum with range check, then clamp or wrap.
  function automatic void model(input int width, input int prods[$],
                                output int acc, output bit ov);
    int hi, lo, m, s, r;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    m  = 1 << width;
    acc = 0;
    ov  = 1'b0;
    foreach (prods[i]) begin
      s = acc + prods[i];
      if (s > hi || s < lo) ov = 1'b1;
`ifdef MAC_SAT_EN
      acc = (s > hi) ? hi : ((s < lo) ? lo : s);
`else
      r = (s - lo) % m;
      if (r < 0) r += m;
      acc = r + lo;
`endif
    end
  endfunction

  task automatic send_beat(input int idx, input int xv, input int wv, input int max_gap);
    int waited;
    in_valid_s[idx] = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    in_valid_s[idx] = 1'b1;
    x_s[idx] = 4'(xv);
    w_s[idx] = 4'(wv);
    waited = 0;
    while (in_ready_s[idx] !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout inst=%0d in_ready=%b required 1", idx, in_ready_s[idx]);
        in_valid_s[idx] = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid_s[idx] = 1'b0;
  endtask

  task automatic run_dot(input int idx, input string name, input int xs[$], input int ws[$],
                         input int max_gap, input bit extra_valid);
    int prods[$];
    int exp_acc;
    bit exp_ovf;
    foreach (xs[i]) prods.push_back(xs[i] * ws[i]);
    model((idx == 2) ? 8 : 12, prods, exp_acc, exp_ovf);

    start_s[idx] = 1'b1;
    @(negedge clk);
    start_s[idx] = 1'b0;
    checks++;
    if (busy_s[idx] !== 1'b1 || ovf_s[idx] !== 1'b0 || acc_of(idx) !== 0) begin
      failures++;
      $display("FAIL %s_start busy=%b ovf=%b acc=%0d required busy=1 ovf=0 acc=0",
               name, busy_s[idx], ovf_s[idx], acc_of(idx));
    end
    foreach (xs[i]) send_beat(idx, xs[i], ws[i], max_gap);

    if (extra_valid) begin
      in_valid_s[idx] = 1'b1;
      x_s[idx] = 4'd7;
      w_s[idx] = 4'd7;
    end
    checks++;
    if (out_valid_s[idx] !== 1'b0 || in_ready_s[idx] !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain0 out_valid=%b in_ready=%b required 0 0",
               name, out_valid_s[idx], in_ready_s[idx]);
    end
    @(negedge clk);
    checks++;
    if (out_valid_s[idx] !== 1'b0 || in_ready_s[idx] !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain1 out_valid=%b in_ready=%b required 0 0",
               name, out_valid_s[idx], in_ready_s[idx]);
    end
    @(negedge clk);
    checks++;
    if (out_valid_s[idx] !== 1'b1 || in_ready_s[idx] !== 1'b0) begin
      failures++;
      $display("FAIL %s_done out_valid=%b in_ready=%b required 1 0",
               name, out_valid_s[idx], in_ready_s[idx]);
    end
    checks++;
    if (acc_of(idx) !== exp_acc || ovf_s[idx] !== exp_ovf) begin
      failures++;
      $display("FAIL %s_result acc=%0d ovf=%b required acc=%0d ovf=%b",
               name, acc_of(idx), ovf_s[idx], exp_acc, exp_ovf);
    end
    in_valid_s[idx] = 1'b0;
  endtask

  task automatic release_result(input int idx, input string name);
    out_ready_s[idx] = 1'b1;
    @(negedge clk);
    out_ready_s[idx] = 1'b0;
    checks++;
    if (out_valid_s[idx] !== 1'b0 || busy_s[idx] !== 1'b0) begin
      failures++;
      $display("FAIL %s_release out_valid=%b busy=%b required 0 0",
               name, out_valid_s[idx], busy_s[idx]);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready_s[i] !== 1'b0 || out_valid_s[i] !== 1'b0 || acc_of(i) !== 0 ||
          ovf_s[i] !== 1'b0 || busy_s[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s inst=%0d in_ready=%b out_valid=%b acc=%0d ovf=%b busy=%b required all 0",
                 name, i, in_ready_s[i], out_valid_s[i], acc_of(i), ovf_s[i], busy_s[i]);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      in_valid_s[i] = 1'b0;
      out_ready_s[i] = 1'b0;
      x_s[i] = 4'd0;
      w_s[i] = 4'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_corner_product();
    int xs[$];
    int ws[$];
    for (int i = 0; i < 16; i++) begin
      xs.push_back(-8);
      ws.push_back(-8);
    end
    run_dot(0, "corner", xs, ws, 0, 1'b0);
    release_result(0, "corner");
  endtask

  task automatic test_gaps_and_hold();
    int xs[$] = '{3, -4, 7, -8};
    int ws[$] = '{2, 5, -1, 1};
    int held;
    run_dot(1, "gaps", xs, ws, 4, 1'b1);
    held = acc_of(1);
    for (int i = 0; i < 10; i++) begin
      start_s[1] = (i % 3 == 0);
      in_valid_s[1] = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (out_valid_s[1] !== 1'b1 || acc_of(1) !== held || in_ready_s[1] !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d out_valid=%b acc=%0d in_ready=%b required 1 %0d 0",
                 i, out_valid_s[1], acc_of(1), in_ready_s[1], held);
      end
    end
    in_valid_s[1] = 1'b0;
    start_s[1] = 1'b1;
    out_ready_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    out_ready_s[1] = 1'b0;
    checks++;
    if (busy_s[1] !== 1'b0 || out_valid_s[1] !== 1'b0) begin
      failures++;
      $display("FAIL hold_exit busy=%b out_valid=%b required 0 0", busy_s[1], out_valid_s[1]);
    end
  endtask

  task automatic test_overflow_and_clear();
    int xs[$] = '{-8, -8, -8, -8};
    int ws[$] = '{-8, -8, -8, -8};
    int sx[$];
    int sw[$];
    run_dot(2, "ovf", xs, ws, 1, 1'b0);
    release_result(2, "ovf");
    for (int i = 0; i < 4; i++) begin
      sx.push_back(int'($urandom_range(0, 4)) - 2);
      sw.push_back(int'($urandom_range(0, 4)) - 2);
    end
    run_dot(2, "ovf_clear", sx, sw, 2, 1'b0);
    release_result(2, "ovf_clear");
  endtask

  task automatic test_reset_mid_run();
    int xs[$];
    int ws[$];
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(0, 1, 1, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      xs.push_back(1);
      ws.push_back(1);
    end
    run_dot(0, "after_reset", xs, ws, 1, 1'b0);
    release_result(0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int idx = 0; idx < 3; idx++) begin
        int xs[$];
        int ws[$];
        int n;
        n = (idx == 0) ? 16 : 4;
        for (int i = 0; i < n; i++) begin
          xs.push_back(int'($urandom_range(0, 15)) - 8);
          ws.push_back(int'($urandom_range(0, 15)) - 8);
        end
        run_dot(idx, $sformatf("rand%0d_%0d", r, idx), xs, ws, 3, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        release_result(idx, $sformatf("rand%0d_%0d", r, idx));
      end
    end
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    test_reset();
    test_corner_product();
    test_gaps_and_hold();
    test_overflow_and_clear();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
